// File: rtl/mat_slot_if.sv
// Handshake bundle between the matrix requesters and the slot allocator.
// The master side is the requester, the slave side is the allocator.
interface mat_slot_if #(
    parameter int ADDR_W = 9
);
    logic              alloc_req;
    logic [2:0]        alloc_m;
    logic [2:0]        alloc_n;
    logic              alloc_ack;
    logic              alloc_err;
    logic [ADDR_W-1:0] alloc_base;
    logic              commit;
    logic              abort;
    logic              busy;
    logic              q_req;
    logic [2:0]        q_m;
    logic [2:0]        q_n;
    logic [1:0]        q_id;
    logic              q_done;
    logic              q_hit;
    logic [ADDR_W-1:0] q_base;
    logic [4:0]        valid_count;

    modport master (
        output alloc_req, alloc_m, alloc_n, commit, abort, q_req, q_m, q_n, q_id,
        input  alloc_ack, alloc_err, alloc_base, busy, q_done, q_hit, q_base, valid_count
    );

    modport slave (
        input  alloc_req, alloc_m, alloc_n, commit, abort, q_req, q_m, q_n, q_id,
        output alloc_ack, alloc_err, alloc_base, busy, q_done, q_hit, q_base, valid_count
    );
endinterface

// File: rtl/mat_slot_allocator.sv
// Fixed-size slot allocator for the shared matrix memory: grants base addresses,
// evicts the oldest matrix per class or globally, and resolves id-th-of-class lookups.
//
// state  | meaning
// IDLE   | waiting for an allocation (priority) or lookup request
// ASCAN  | walking all slots to pick the allocation victim
// GRANT  | alloc_ack pulse; victim invalidated before it is overwritten
// PEND   | requester writing the slot; waits for commit or abort
// QSCAN  | walking all slots to find the id-th matching matrix
module mat_slot_allocator #(
    parameter int NUM_SLOTS   = 20,
    parameter int SLOT_WORDS  = 25,
    parameter int ADDR_W      = 9,
    parameter int PER_DIM_MAX = 2
) (
    input  logic       clk,
    input  logic       rst,
    mat_slot_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_SLOTS);
    localparam int CNT_W = $clog2(NUM_SLOTS + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ASCAN = 3'd1;
    localparam logic [2:0] S_GRANT = 3'd2;
    localparam logic [2:0] S_PEND  = 3'd3;
    localparam logic [2:0] S_QSCAN = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [2:0]           req_m_q, req_m_d;
    logic [2:0]           req_n_q, req_n_d;
    logic [1:0]           req_id_q, req_id_d;

    logic [NUM_SLOTS-1:0] valid_q, valid_d;
    logic [2:0]           slot_m_q [NUM_SLOTS];
    logic [2:0]           slot_m_d [NUM_SLOTS];
    logic [2:0]           slot_n_q [NUM_SLOTS];
    logic [2:0]           slot_n_d [NUM_SLOTS];
    logic [7:0]           age_q    [NUM_SLOTS];
    logic [7:0]           age_d    [NUM_SLOTS];

    // The same-class trackers double as the lookup match counter / hit slot in QSCAN.
    logic [CNT_W-1:0]     sc_cnt_q, sc_cnt_d;
    logic [IDX_W-1:0]     sc_idx_q, sc_idx_d;
    logic [7:0]           sc_age_q, sc_age_d;
    logic                 sc_found_q, sc_found_d;
    logic [IDX_W-1:0]     free_idx_q, free_idx_d;
    logic                 free_found_q, free_found_d;
    logic [IDX_W-1:0]     old_idx_q, old_idx_d;
    logic [7:0]           old_age_q, old_age_d;
    logic                 old_found_q, old_found_d;
    logic [IDX_W-1:0]     victim_q, victim_d;

    logic                 alloc_ack_q, alloc_ack_d;
    logic                 alloc_err_q, alloc_err_d;
    logic [ADDR_W-1:0]    alloc_base_q, alloc_base_d;
    logic                 busy_q, busy_d;
    logic                 q_done_q, q_done_d;
    logic                 q_hit_q, q_hit_d;
    logic [ADDR_W-1:0]    q_base_q, q_base_d;
    logic [4:0]           valid_count_q, valid_count_d;

    logic                 cur_valid, cur_match, last_idx, dims_legal;
    logic [7:0]           cur_age;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        req_m_d       = req_m_q;
        req_n_d       = req_n_q;
        req_id_d      = req_id_q;
        valid_d       = valid_q;
        slot_m_d      = slot_m_q;
        slot_n_d      = slot_n_q;
        age_d         = age_q;
        sc_cnt_d      = sc_cnt_q;
        sc_idx_d      = sc_idx_q;
        sc_age_d      = sc_age_q;
        sc_found_d    = sc_found_q;
        free_idx_d    = free_idx_q;
        free_found_d  = free_found_q;
        old_idx_d     = old_idx_q;
        old_age_d     = old_age_q;
        old_found_d   = old_found_q;
        victim_d      = victim_q;
        alloc_ack_d   = 1'b0;
        alloc_err_d   = 1'b0;
        alloc_base_d  = alloc_base_q;
        busy_d        = busy_q;
        q_done_d      = 1'b0;
        q_hit_d       = q_hit_q;
        q_base_d      = q_base_q;
        valid_count_d = 5'($countones(valid_q));

        cur_valid  = valid_q[idx_q];
        cur_age    = age_q[idx_q];
        cur_match  = cur_valid && (slot_m_q[idx_q] == req_m_q) && (slot_n_q[idx_q] == req_n_q);
        last_idx   = (idx_q == IDX_W'(NUM_SLOTS - 1));
        dims_legal = (bus.alloc_m != 3'd0) && (bus.alloc_m <= 3'd5) &&
                     (bus.alloc_n != 3'd0) && (bus.alloc_n <= 3'd5);

        case (state_q)
            S_IDLE: begin
                if (bus.alloc_req) begin
                    req_m_d = bus.alloc_m;
                    req_n_d = bus.alloc_n;
                    if (dims_legal) begin
                        state_d      = S_ASCAN;
                        idx_d        = '0;
                        busy_d       = 1'b1;
                        sc_cnt_d     = '0;
                        sc_found_d   = 1'b0;
                        free_found_d = 1'b0;
                        old_found_d  = 1'b0;
                    end else begin
                        alloc_err_d = 1'b1;
                    end
                end else if (bus.q_req) begin
                    req_m_d    = bus.q_m;
                    req_n_d    = bus.q_n;
                    req_id_d   = bus.q_id;
                    state_d    = S_QSCAN;
                    idx_d      = '0;
                    sc_cnt_d   = '0;
                    sc_found_d = 1'b0;
                end
            end

            S_ASCAN: begin
                if (cur_match) begin
                    sc_cnt_d = sc_cnt_q + CNT_W'(1);
                    if (!sc_found_q || (cur_age > sc_age_q)) begin
                        sc_found_d = 1'b1;
                        sc_idx_d   = idx_q;
                        sc_age_d   = cur_age;
                    end
                end
                if (!cur_valid && !free_found_q) begin
                    free_found_d = 1'b1;
                    free_idx_d   = idx_q;
                end
                if (cur_valid && (!old_found_q || (cur_age > old_age_q))) begin
                    old_found_d = 1'b1;
                    old_idx_d   = idx_q;
                    old_age_d   = cur_age;
                end
                if (last_idx) begin
                    if (sc_cnt_d >= CNT_W'(PER_DIM_MAX))
                        victim_d = sc_idx_d;
                    else if (free_found_d)
                        victim_d = free_idx_d;
                    else
                        victim_d = old_idx_d;
                    alloc_ack_d  = 1'b1;
                    alloc_base_d = ADDR_W'(victim_d) * ADDR_W'(SLOT_WORDS);
                    state_d      = S_GRANT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            S_GRANT: begin
                valid_d[victim_q] = 1'b0;
                state_d           = S_PEND;
            end

            S_PEND: begin
                if (bus.abort) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (bus.commit) begin
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (valid_q[i] && (age_q[i] != 8'd255))
                            age_d[i] = age_q[i] + 8'd1;
                    end
                    valid_d[victim_q]  = 1'b1;
                    slot_m_d[victim_q] = req_m_q;
                    slot_n_d[victim_q] = req_n_q;
                    age_d[victim_q]    = 8'd0;
                    busy_d             = 1'b0;
                    state_d            = S_IDLE;
                end
            end

            S_QSCAN: begin
                if (cur_match) begin
                    sc_cnt_d = sc_cnt_q + CNT_W'(1);
                    if (!sc_found_q && (req_id_q != 2'd0) && (sc_cnt_d == CNT_W'(req_id_q))) begin
                        sc_found_d = 1'b1;
                        sc_idx_d   = idx_q;
                    end
                end
                if (last_idx) begin
                    q_done_d = 1'b1;
                    q_hit_d  = sc_found_d;
                    q_base_d = sc_found_d ? ADDR_W'(sc_idx_d) * ADDR_W'(SLOT_WORDS) : '0;
                    state_d  = S_IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            req_m_q       <= '0;
            req_n_q       <= '0;
            req_id_q      <= '0;
            valid_q       <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_m_q[i] <= '0;
                slot_n_q[i] <= '0;
                age_q[i]    <= '0;
            end
            sc_cnt_q      <= '0;
            sc_idx_q      <= '0;
            sc_age_q      <= '0;
            sc_found_q    <= 1'b0;
            free_idx_q    <= '0;
            free_found_q  <= 1'b0;
            old_idx_q     <= '0;
            old_age_q     <= '0;
            old_found_q   <= 1'b0;
            victim_q      <= '0;
            alloc_ack_q   <= 1'b0;
            alloc_err_q   <= 1'b0;
            alloc_base_q  <= '0;
            busy_q        <= 1'b0;
            q_done_q      <= 1'b0;
            q_hit_q       <= 1'b0;
            q_base_q      <= '0;
            valid_count_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            req_m_q       <= req_m_d;
            req_n_q       <= req_n_d;
            req_id_q      <= req_id_d;
            valid_q       <= valid_d;
            slot_m_q      <= slot_m_d;
            slot_n_q      <= slot_n_d;
            age_q         <= age_d;
            sc_cnt_q      <= sc_cnt_d;
            sc_idx_q      <= sc_idx_d;
            sc_age_q      <= sc_age_d;
            sc_found_q    <= sc_found_d;
            free_idx_q    <= free_idx_d;
            free_found_q  <= free_found_d;
            old_idx_q     <= old_idx_d;
            old_age_q     <= old_age_d;
            old_found_q   <= old_found_d;
            victim_q      <= victim_d;
            alloc_ack_q   <= alloc_ack_d;
            alloc_err_q   <= alloc_err_d;
            alloc_base_q  <= alloc_base_d;
            busy_q        <= busy_d;
            q_done_q      <= q_done_d;
            q_hit_q       <= q_hit_d;
            q_base_q      <= q_base_d;
            valid_count_q <= valid_count_d;
        end
    end

    assign bus.alloc_ack   = alloc_ack_q;
    assign bus.alloc_err   = alloc_err_q;
    assign bus.alloc_base  = alloc_base_q;
    assign bus.busy        = busy_q;
    assign bus.q_done      = q_done_q;
    assign bus.q_hit       = q_hit_q;
    assign bus.q_base      = q_base_q;
    assign bus.valid_count = valid_count_q;

endmodule

// File: tb/tb_mat_slot_allocator.sv
// Bench for mat_slot_allocator: constant vector table, hand-written corner sequences,
// and random traffic checked against a slot-level reference model.
module tb_mat_slot_allocator;
    localparam int NS = 20;
    localparam int SW = 25;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mat_slot_if #(.ADDR_W(9)) bus ();

    mat_slot_allocator #(.NUM_SLOTS(NS), .SLOT_WORDS(SW), .ADDR_W(9), .PER_DIM_MAX(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one entry per slot.
    int mv [NS];
    int mm [NS];
    int mn [NS];
    int mage [NS];

    typedef struct {
        int op;        // 0 alloc+commit, 1 alloc+abort, 2 query
        int m;
        int n;
        int id;
        int exp_err;
        int exp_base;
        int exp_hit;
        int exp_vc;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            mv[i] = 0; mm[i] = 0; mn[i] = 0; mage[i] = 0;
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < NS; i++) c += mv[i];
        return c;
    endfunction

    function automatic int oldest_of(input int idxs[$]);
        int best = -1;
        foreach (idxs[k])
            if (best < 0 || mage[idxs[k]] > mage[best]) best = idxs[k];
        return best;
    endfunction

    function automatic int model_victim(input int m, input int n);
        int same[$];
        int used[$];
        int free_slots[$];
        for (int i = 0; i < NS; i++) begin
            if (mv[i] == 0) free_slots.push_back(i);
            else begin
                used.push_back(i);
                if (mm[i] == m && mn[i] == n) same.push_back(i);
            end
        end
        if (same.size() >= 2) return oldest_of(same);
        if (free_slots.size() > 0) return free_slots[0];
        return oldest_of(used);
    endfunction

    task automatic model_commit(input int v, input int m, input int n);
        for (int i = 0; i < NS; i++)
            if (mv[i] != 0 && mage[i] < 255) mage[i]++;
        mv[v] = 1; mm[v] = m; mn[v] = n; mage[v] = 0;
    endtask

    task automatic model_query(input int m, input int n, input int id, output int hit, output int base);
        int seen = 0;
        hit = 0; base = 0;
        for (int i = 0; i < NS; i++) begin
            if (mv[i] != 0 && mm[i] == m && mn[i] == n) begin
                seen++;
                if (hit == 0 && id != 0 && seen == id) begin
                    hit = 1; base = i * SW;
                end
            end
        end
    endtask

    task automatic do_reset();
        bus.alloc_req = 0; bus.alloc_m = 0; bus.alloc_n = 0;
        bus.commit = 0; bus.abort = 0;
        bus.q_req = 0; bus.q_m = 0; bus.q_n = 0; bus.q_id = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic do_alloc(input int m, input int n, output int ack, output int err, output int lat, output int base);
        bus.alloc_m = 3'(m); bus.alloc_n = 3'(n); bus.alloc_req = 1;
        lat = 0; ack = 0; err = 0;
        while (ack == 0 && err == 0 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            ack = int'(bus.alloc_ack);
            err = int'(bus.alloc_err);
        end
        base = int'(bus.alloc_base);
        bus.alloc_req = 0;
    endtask

    task automatic finish_alloc(input bit do_commit, input bit do_abort);
        @(posedge clk); #1;
        chk("ack_single_pulse", int'(bus.alloc_ack), 0);
        chk("busy_in_pend", int'(bus.busy), 1);
        bus.commit = do_commit; bus.abort = do_abort;
        @(posedge clk); #1;
        bus.commit = 0; bus.abort = 0;
        chk("busy_after_end", int'(bus.busy), 0);
    endtask

    task automatic do_query(input int m, input int n, input int id, output int hit, output int base, output int lat);
        int done = 0;
        bus.q_m = 3'(m); bus.q_n = 3'(n); bus.q_id = 2'(id); bus.q_req = 1;
        lat = 0;
        while (done == 0 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            done = int'(bus.q_done);
        end
        hit = int'(bus.q_hit); base = int'(bus.q_base);
        bus.q_req = 0;
    endtask

    task automatic alloc_commit_chk(input string name, input int m, input int n, input int exp_base);
        int ack, err, lat, base;
        do_alloc(m, n, ack, err, lat, base);
        chk({name, "_ack"}, ack, 1);
        chk({name, "_base"}, base, exp_base);
        finish_alloc(1'b1, 1'b0);
    endtask

    initial begin
        int ack, err, lat, base, hit, ehit, ebase, v, m, n, id, r, f;

        vecs[0]  = '{0, 3, 3, 0, 0,   0, 0, 1};
        vecs[1]  = '{0, 2, 4, 0, 0,  25, 0, 2};
        vecs[2]  = '{0, 0, 3, 0, 1,   0, 0, 2};
        vecs[3]  = '{0, 6, 2, 0, 1,   0, 0, 2};
        vecs[4]  = '{0, 3, 0, 0, 1,   0, 0, 2};
        vecs[5]  = '{0, 2, 2, 0, 0,  50, 0, 3};
        vecs[6]  = '{0, 2, 2, 0, 0,  75, 0, 4};
        vecs[7]  = '{0, 2, 2, 0, 0,  50, 0, 4};
        vecs[8]  = '{2, 2, 2, 1, 0,  50, 1, 4};
        vecs[9]  = '{2, 2, 2, 2, 0,  75, 1, 4};
        vecs[10] = '{2, 2, 2, 3, 0,   0, 0, 4};
        vecs[11] = '{2, 2, 2, 0, 0,   0, 0, 4};
        vecs[12] = '{2, 3, 3, 1, 0,   0, 1, 4};
        vecs[13] = '{2, 5, 5, 1, 0,   0, 0, 4};
        vecs[14] = '{1, 4, 4, 0, 0, 100, 0, 4};
        vecs[15] = '{0, 5, 5, 0, 0, 100, 0, 5};
        vecs[16] = '{2, 5, 5, 1, 0, 100, 1, 5};
        vecs[17] = '{0, 2, 2, 0, 0,  75, 0, 5};

        do_reset();
        chk("rst_alloc_ack",   int'(bus.alloc_ack), 0);
        chk("rst_alloc_err",   int'(bus.alloc_err), 0);
        chk("rst_alloc_base",  int'(bus.alloc_base), 0);
        chk("rst_busy",        int'(bus.busy), 0);
        chk("rst_q_done",      int'(bus.q_done), 0);
        chk("rst_q_hit",       int'(bus.q_hit), 0);
        chk("rst_q_base",      int'(bus.q_base), 0);
        chk("rst_valid_count", int'(bus.valid_count), 0);

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].op == 2) begin
                do_query(vecs[i].m, vecs[i].n, vecs[i].id, hit, base, lat);
                chk($sformatf("vec%0d_q_lat", i), lat, 21);
                chk($sformatf("vec%0d_q_hit", i), hit, vecs[i].exp_hit);
                chk($sformatf("vec%0d_q_base", i), base, vecs[i].exp_base);
            end else begin
                do_alloc(vecs[i].m, vecs[i].n, ack, err, lat, base);
                if (vecs[i].exp_err != 0) begin
                    chk($sformatf("vec%0d_err", i), err, 1);
                    chk($sformatf("vec%0d_err_lat", i), lat, 1);
                    chk($sformatf("vec%0d_err_noack", i), ack, 0);
                    chk($sformatf("vec%0d_err_busy", i), int'(bus.busy), 0);
                end else begin
                    chk($sformatf("vec%0d_ack", i), ack, 1);
                    chk($sformatf("vec%0d_ack_lat", i), lat, 21);
                    chk($sformatf("vec%0d_base", i), base, vecs[i].exp_base);
                    finish_alloc(vecs[i].op == 0, vecs[i].op == 1);
                end
                @(posedge clk); #1;
                chk($sformatf("vec%0d_vc", i), int'(bus.valid_count), vecs[i].exp_vc);
            end
        end

        // Reset in the middle of an allocation scan.
        bus.alloc_m = 3'd1; bus.alloc_n = 3'd1; bus.alloc_req = 1;
        repeat (5) @(posedge clk);
        #2 rst = 1;
        #1;
        chk("midrst_busy",  int'(bus.busy), 0);
        chk("midrst_vc",    int'(bus.valid_count), 0);
        chk("midrst_base",  int'(bus.alloc_base), 0);
        chk("midrst_q_hit", int'(bus.q_hit), 0);
        chk("midrst_q_base",int'(bus.q_base), 0);
        bus.alloc_req = 0;
        @(posedge clk); #1 rst = 0;
        @(posedge clk); #1;
        model_reset();
        do_query(5, 5, 1, hit, base, lat);
        chk("empty_miss_hit", hit, 0);
        chk("empty_miss_base", base, 0);

        // Per-class eviction: third 2x2 reuses slot 0 (oldest of the class).
        do_reset();
        alloc_commit_chk("cls1", 2, 2, 0);
        alloc_commit_chk("cls2", 2, 2, 25);
        alloc_commit_chk("cls3", 2, 2, 0);
        @(posedge clk); #1;
        chk("cls_vc", int'(bus.valid_count), 2);
        do_query(2, 2, 1, hit, base, lat);
        chk("cls_q1_hit", hit, 1);
        chk("cls_q1_base", base, 0);
        do_query(2, 2, 2, hit, base, lat);
        chk("cls_q2_hit", hit, 1);
        chk("cls_q2_base", base, 25);

        // Full memory: twenty distinct classes, slot i committed i-th.
        do_reset();
        for (int i = 0; i < NS; i++)
            alloc_commit_chk($sformatf("fill%0d", i), (i % 5) + 1, (i / 5) + 1, i * SW);
        @(posedge clk); #1;
        chk("full_vc", int'(bus.valid_count), 20);
        do_alloc(5, 5, ack, err, lat, base);
        chk("full_evict_base", base, 0);
        finish_alloc(1'b0, 1'b1);
        @(posedge clk); #1;
        chk("full_abort_vc", int'(bus.valid_count), 19);
        do_query(1, 1, 1, hit, base, lat);
        chk("full_abort_miss", hit, 0);
        alloc_commit_chk("refill", 5, 5, 0);
        alloc_commit_chk("evict_global", 5, 5, 25);
        alloc_commit_chk("evict_class", 5, 5, 0);

        // Allocation and lookup requested together: allocation served first.
        do_reset();
        bus.alloc_m = 3'd4; bus.alloc_n = 3'd4; bus.alloc_req = 1;
        bus.q_m = 3'd4; bus.q_n = 3'd4; bus.q_id = 2'd1; bus.q_req = 1;
        lat = 0; ack = 0; f = 0;
        while (ack == 0 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            ack = int'(bus.alloc_ack);
            f += int'(bus.q_done);
        end
        bus.alloc_req = 0;
        chk("simul_ack_lat", lat, 21);
        chk("simul_no_early_qdone", f, 0);
        finish_alloc(1'b1, 1'b0);
        lat = 1; f = 0;
        while (f == 0 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            f = int'(bus.q_done);
        end
        bus.q_req = 0;
        chk("simul_q_lat_after_commit", lat, 22);
        chk("simul_q_hit", int'(bus.q_hit), 1);
        chk("simul_q_base", int'(bus.q_base), 0);

        // Commit and abort together: abort wins.
        do_alloc(1, 5, ack, err, lat, base);
        chk("ca_base", base, 25);
        finish_alloc(1'b1, 1'b1);
        @(posedge clk); #1;
        chk("ca_vc", int'(bus.valid_count), 1);
        do_query(1, 5, 1, hit, base, lat);
        chk("ca_miss", hit, 0);

        // Random traffic against the reference model.
        do_reset();
        for (int t = 0; t < 70; t++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                if ($urandom_range(0, 9) == 0) m = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(6, 7);
                else m = $urandom_range(1, 5);
                n = $urandom_range(1, 2);
                do_alloc(m, n, ack, err, lat, base);
                if (m < 1 || m > 5) begin
                    chk("rnd_err", err, 1);
                    chk("rnd_err_lat", lat, 1);
                end else begin
                    v = model_victim(m, n);
                    chk("rnd_ack", ack, 1);
                    chk("rnd_ack_lat", lat, 21);
                    chk("rnd_base", base, v * SW);
                    mv[v] = 0;
                    f = $urandom_range(0, 3);
                    finish_alloc(f != 0, f < 2);
                    if (f >= 2) model_commit(v, m, n);
                    @(posedge clk); #1;
                    chk("rnd_vc", int'(bus.valid_count), model_count());
                end
            end else begin
                m = $urandom_range(1, 5);
                n = $urandom_range(1, 2);
                id = $urandom_range(0, 3);
                model_query(m, n, id, ehit, ebase);
                do_query(m, n, id, hit, base, lat);
                chk("rnd_q_lat", lat, 21);
                chk("rnd_q_hit", hit, ehit);
                chk("rnd_q_base", base, ebase);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
